box_draw_engine: RTL and testbench

//   Rasterises one solid axis-aligned rectangle per request into pixel writes for the VGA

---
 rtl/box_draw_engine_pkg.sv | 27 ++
 rtl/box_draw_engine_if.sv | 29 ++
 rtl/box_draw_engine_scan_counter.sv | 47 ++++
 rtl/box_draw_engine.sv | 122 ++++++++++++
 tb/tb_box_draw_engine.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/box_draw_engine_pkg.sv
// Shared VGA frame constants, colours and the box engine state encoding.
// Imported by every file of the box draw engine slice.
package box_draw_engine_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int DIM_W    = 5;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] COL_BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] COL_RED   = 3'b100;
  localparam logic [COLOUR_W-1:0] COL_WHITE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DRAW   = 2'b01,
    ST_FINISH = 2'b10
  } state_t;

  // Sums are one bit wider than the coordinate so off-screen pixels never wrap back on.
  function automatic logic on_screen(input logic [X_W:0] px, input logic [Y_W:0] py);
    return (int'(px) < SCREEN_W) && (int'(py) < SCREEN_H);
  endfunction

endpackage

// File: rtl/box_draw_engine_if.sv
// Request handshake plus pixel bus between a game-object stage, the box engine
// and the VGA adapter.
interface box_draw_engine_if;
  import box_draw_engine_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [X_W-1:0]      req_x;
  logic [Y_W-1:0]      req_y;
  logic [DIM_W-1:0]    req_w;
  logic [DIM_W-1:0]    req_h;
  logic [COLOUR_W-1:0] req_colour;
  logic [X_W-1:0]      x;
  logic [Y_W-1:0]      y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                done;

  modport master (
    output req_valid, req_x, req_y, req_w, req_h, req_colour,
    input  req_ready, x, y, colour, plot, done
  );

  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h, req_colour,
    output req_ready, x, y, colour, plot, done
  );

endinterface

// File: rtl/box_draw_engine_scan_counter.sv
// Nested dx/dy raster counter: dx runs fastest, load clears to (0,0) and captures the box size.
// Exposes the following position and a flag for the final position of the box.
module box_scan_counter
  import box_draw_engine_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [DIM_W-1:0] w,
  input  logic [DIM_W-1:0] h,
  output logic [DIM_W-1:0] next_dx,
  output logic [DIM_W-1:0] next_dy,
  output logic             last
);

  logic [DIM_W-1:0] dx;
  logic [DIM_W-1:0] dy;
  logic [DIM_W-1:0] w_q;
  logic [DIM_W-1:0] h_q;
  logic             row_end;

  always_comb begin
    row_end = (dx == w_q - 1'b1);
    last    = row_end && (dy == h_q - 1'b1);
    next_dx = row_end ? '0 : dx + 1'b1;
    next_dy = row_end ? dy + 1'b1 : dy;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dx  <= '0;
      dy  <= '0;
      w_q <= '0;
      h_q <= '0;
    end else if (load) begin
      dx  <= '0;
      dy  <= '0;
      w_q <= w;
      h_q <= h;
    end else if (enable) begin
      dx <= next_dx;
      dy <= next_dy;
    end
  end

endmodule

// File: rtl/box_draw_engine.sv
// Rasterises one solid rectangle per request into one pixel write per cycle,
// clipping pixels that fall outside the 160x120 frame without changing timing.
module box_draw_engine
  import box_draw_engine_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  box_draw_engine_if.slave bus
);

  state_t              state;
  state_t              next_state;
  logic [X_W-1:0]      x0_q;
  logic [Y_W-1:0]      y0_q;
  logic [COLOUR_W-1:0] colour_q;
  logic                empty_box;
  logic                scan_load;
  logic                scan_enable;
  logic                scan_last;
  logic                emit;
  logic [DIM_W-1:0]    next_dx;
  logic [DIM_W-1:0]    next_dy;
  logic [X_W:0]        pix_x;
  logic [Y_W:0]        pix_y;
  logic [COLOUR_W-1:0] pix_colour;
  logic                pix_visible;

  assign empty_box = (bus.req_w == '0) || (bus.req_h == '0);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // The accept edge already registers pixel (0,0); each DRAW edge registers the next one.
  always_comb begin
    next_state    = state;
    scan_load     = 1'b0;
    scan_enable   = 1'b0;
    emit          = 1'b0;
    bus.req_ready = 1'b0;
    bus.done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          scan_load  = 1'b1;
          emit       = !empty_box;
          next_state = empty_box ? ST_FINISH : ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (scan_last) begin
          next_state = ST_FINISH;
        end else begin
          scan_enable = 1'b1;
          emit        = 1'b1;
        end
      end
      ST_FINISH: begin
        bus.done   = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  box_scan_counter u_scan (
    .clock   (clock),
    .reset   (reset),
    .load    (scan_load),
    .enable  (scan_enable),
    .w       (bus.req_w),
    .h       (bus.req_h),
    .next_dx (next_dx),
    .next_dy (next_dy),
    .last    (scan_last)
  );

  always_comb begin
    if (state == ST_IDLE) begin
      pix_x      = {1'b0, bus.req_x};
      pix_y      = {1'b0, bus.req_y};
      pix_colour = bus.req_colour;
    end else begin
      pix_x      = {1'b0, x0_q} + {{(X_W + 1 - DIM_W){1'b0}}, next_dx};
      pix_y      = {1'b0, y0_q} + {{(Y_W + 1 - DIM_W){1'b0}}, next_dy};
      pix_colour = colour_q;
    end
    pix_visible = emit && on_screen(pix_x, pix_y);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x0_q     <= '0;
      y0_q     <= '0;
      colour_q <= COL_BLACK;
    end else if (scan_load) begin
      x0_q     <= bus.req_x;
      y0_q     <= bus.req_y;
      colour_q <= bus.req_colour;
    end
  end

  // Coordinates only move on a real write, so they hold through clipped pixels.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.x      <= '0;
      bus.y      <= '0;
      bus.colour <= COL_BLACK;
      bus.plot   <= 1'b0;
    end else begin
      bus.plot <= pix_visible;
      if (pix_visible) begin
        bus.x      <= pix_x[X_W-1:0];
        bus.y      <= pix_y[Y_W-1:0];
        bus.colour <= pix_colour;
      end
    end
  end

endmodule

// File: tb/tb_box_draw_engine.sv
// Directed and random box requests checked cycle by cycle against a golden
// pixel list built from the rectangle/clipping rules.
module tb_box_draw_engine;
  import box_draw_engine_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  box_draw_engine_if bus ();

  box_draw_engine dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int clip_len(input int start, input int len, input int limit);
    if (start >= limit) return 0;
    return (len < limit - start) ? len : limit - start;
  endfunction

  // Issues one request, then checks every cycle until the engine is ready again.
  // hold_next keeps req_valid high with the next box's fields during the draw;
  // abort_at > 0 asserts reset right after pixel number abort_at is seen.
  task automatic applyStimulus(input int bx, input int by, input int bw, input int bh,
                               input int bc, input bit hold_next, input int nx,
                               input int ny, input int nw, input int nh, input int nc,
                               input int abort_at);
    int gx[$];
    int gy[$];
    int budget;
    int plots;
    int total;
    int vis;
    int px;
    int py;

    for (int j = 0; j < bh; j++)
      for (int i = 0; i < bw; i++)
        if (bx + i < SCREEN_W && by + j < SCREEN_H) begin
          gx.push_back(bx + i);
          gy.push_back(by + j);
        end

    bus.req_x      = bx[X_W-1:0];
    bus.req_y      = by[Y_W-1:0];
    bus.req_w      = bw[DIM_W-1:0];
    bus.req_h      = bh[DIM_W-1:0];
    bus.req_colour = bc[COLOUR_W-1:0];
    bus.req_valid  = 1'b1;

    budget = 0;
    while (!bus.req_ready && budget < 2000) begin
      @(negedge clock);
      budget++;
    end
    if (!bus.req_ready) begin
      checkOutput("accept_timeout", 32'(bus.req_ready), 1);
      bus.req_valid = 1'b0;
      return;
    end

    @(posedge clock);
    #1;
    if (hold_next) begin
      bus.req_x      = nx[X_W-1:0];
      bus.req_y      = ny[Y_W-1:0];
      bus.req_w      = nw[DIM_W-1:0];
      bus.req_h      = nh[DIM_W-1:0];
      bus.req_colour = nc[COLOUR_W-1:0];
    end else begin
      bus.req_valid  = 1'b0;
      bus.req_x      = X_W'($urandom);
      bus.req_y      = Y_W'($urandom);
      bus.req_w      = DIM_W'($urandom);
      bus.req_h      = DIM_W'($urandom);
      bus.req_colour = COLOUR_W'($urandom);
    end

    plots = 0;
    total = bw * bh;
    for (int k = 0; k < total; k++) begin
      @(negedge clock);
      px  = bx + k % bw;
      py  = by + k / bw;
      vis = (px < SCREEN_W && py < SCREEN_H) ? 1 : 0;
      checkOutput($sformatf("plot k=%0d", k), 32'(bus.plot), vis);
      checkOutput($sformatf("busy_ready k=%0d", k), 32'(bus.req_ready), 0);
      checkOutput($sformatf("early_done k=%0d", k), 32'(bus.done), 0);
      if (bus.plot === 1'b1) begin
        plots++;
        if (gx.size() == 0) begin
          checkOutput("extra_pixel", gx.size(), 1);
        end else begin
          checkOutput($sformatf("x k=%0d", k), 32'(bus.x), gx.pop_front());
          checkOutput($sformatf("y k=%0d", k), 32'(bus.y), gy.pop_front());
          checkOutput($sformatf("colour k=%0d", k), 32'(bus.colour), bc);
        end
      end
      if (abort_at > 0 && k == abort_at - 1) begin
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort_plot", 32'(bus.plot), 0);
        checkOutput("abort_done", 32'(bus.done), 0);
        checkOutput("abort_ready", 32'(bus.req_ready), 1);
        reset = 1'b0;
        repeat (3) begin
          @(negedge clock);
          checkOutput("post_abort_done", 32'(bus.done), 0);
          checkOutput("post_abort_plot", 32'(bus.plot), 0);
        end
        return;
      end
    end

    @(negedge clock);
    checkOutput("done_pulse", 32'(bus.done), 1);
    checkOutput("done_plot", 32'(bus.plot), 0);
    checkOutput("done_ready", 32'(bus.req_ready), 0);
    @(negedge clock);
    checkOutput("done_clear", 32'(bus.done), 0);
    checkOutput("ready_again", 32'(bus.req_ready), 1);
    checkOutput("plot_count", plots, clip_len(bx, bw, SCREEN_W) * clip_len(by, bh, SCREEN_H));
    checkOutput("golden_left", gx.size(), 0);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.req_w      = '0;
    bus.req_h      = '0;
    bus.req_colour = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_x", 32'(bus.x), 0);
    checkOutput("reset_y", 32'(bus.y), 0);
    checkOutput("reset_colour", 32'(bus.colour), 0);
    checkOutput("reset_plot", 32'(bus.plot), 0);
    checkOutput("reset_done", 32'(bus.done), 0);
    checkOutput("reset_ready", 32'(bus.req_ready), 1);
    reset = 1'b0;

    $display("[TB] idle 20 cycles");
    repeat (20) begin
      @(negedge clock);
      checkOutput("idle_plot", 32'(bus.plot), 0);
      checkOutput("idle_done", 32'(bus.done), 0);
      checkOutput("idle_ready", 32'(bus.req_ready), 1);
    end

    $display("[TB] 4x4 red box at (10,20)");
    applyStimulus(10, 20, 4, 4, int'(COL_RED), 1'b0, 0, 0, 0, 0, 0, 0);

    $display("[TB] 16x16 white box clipped at (150,110)");
    applyStimulus(150, 110, 16, 16, int'(COL_WHITE), 1'b0, 0, 0, 0, 0, 0, 0);

    $display("[TB] zero-width box");
    applyStimulus(30, 40, 0, 5, 3, 1'b0, 0, 0, 0, 0, 0, 0);

    $display("[TB] second request held during a draw");
    applyStimulus(50, 60, 4, 4, 2, 1'b1, 52, 61, 4, 4, 1, 0);
    applyStimulus(52, 61, 4, 4, 1, 1'b0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset at 8th pixel");
    applyStimulus(70, 80, 4, 4, 3, 1'b0, 0, 0, 0, 0, 0, 8);
    applyStimulus(70, 80, 4, 4, 6, 1'b0, 0, 0, 0, 0, 0, 0);

    $display("[TB] random boxes");
    repeat (12) begin
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 7)), 1'b0, 0, 0, 0, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
